button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end stage for the five board push-buttons; sits directly upstream of fsm_timer and drives its B_U, B_D, B_L, B_R, B_C inputs.
- Synchronises the raw asynchronous button pins and debounces each one independently.
- Emits one-cycle press pulses, plus auto-repeat pulses for held direction buttons.
- Also exports the debounced button levels for other consumers.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive cycles a synchronised input must differ from the stable level before the level flips; 10 ms at 100 MHz; must be >= 1.
- REPEAT_DELAY, 50_000_000: cycles from the initial press pulse to the first auto-repeat pulse; must be >= 1.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeat pulses; must be >= 1.
- REPEAT_MASK, 5'b11110: per-button auto-repeat enable, bit order {U,D,L,R,C}; C does not repeat by default.
- CNT_W, 26: width of every internal counter; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, btn_c_raw  in  1 each  raw asynchronous pins, active-high
- B_U, B_D, B_L, B_R, B_C  out  1 each  one-cycle press/repeat pulses to fsm_timer
- btn_level  out  5  debounced levels, {U,D,L,R,C}

Behaviour:
- Reset is synchronous and active-high. While reset is sampled high at a clk edge, all state clears after that edge:
  - synchroniser flops, stable levels, counters and repeat FSMs all clear;
  - btn_level=0 and every pulse output is 0.
- Synchroniser: two flops per button, reset value 0. No logic between the two stages.
- Debounce, per button, with stable level S and counter cnt:
  - If sync==S: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: S<=sync and cnt<=0.
  - Else: cnt<=cnt+1.
  - A run of differing samples shorter than DEBOUNCE_CYCLES leaves S unchanged.
- Latency: the raw pin goes high and stays high, first sampled at edge 0. S, and therefore btn_level, goes high after edge DEBOUNCE_CYCLES+1. Release has the same latency.
- Press pulse: the pulse output is high for exactly one cycle: the first cycle in which btn_level for that button reads 1 (registered alongside S). Release produces no pulse.
- Repeat FSM, per button with its REPEAT_MASK bit set. States IDLE, DELAY, REPEAT; counter rcnt.
  - IDLE: on a press pulse go to DELAY with rcnt<=0.
  - DELAY:
    - if S==0, go to IDLE;
    - else if rcnt==REPEAT_DELAY-1, pulse for one cycle, go to REPEAT, rcnt<=0;
    - else rcnt<=rcnt+1.
  - REPEAT:
    - if S==0, go to IDLE;
    - else if rcnt==REPEAT_PERIOD-1, pulse, rcnt<=0;
    - else rcnt<=rcnt+1.
  - Pulse timing: press pulse at cycle t gives the first repeat pulse at t+REPEAT_DELAY, then further pulses every REPEAT_PERIOD cycles.
  - A release at any point returns the FSM to IDLE with no further pulses.
- Buttons with REPEAT_MASK bit 0 produce only the press pulse.
- Buttons are fully independent:
  - simultaneous presses give pulses in the same cycle;
  - there is no priority or masking between buttons.
- Pulse outputs are registered; there are no combinational paths from the raw inputs to any output.
- Reset mid-operation: all pulses drop and every FSM returns to IDLE on the reset edge. A button still held when reset deasserts is treated as a new press. Its pulse appears after DEBOUNCE_CYCLES+2 cycles, counted from the first post-reset edge.
- Counters never wrap: the terminal compare always fires before CNT_W overflow, given the parameter constraint above.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset: assert reset for 3 cycles with all raw pins 0 → btn_level=5'b00000 and all B_* are 0 throughout and after.
- Clean press: btn_u_raw=1 from edge 0 for 12 cycles, then 0 →
  - btn_level[4] rises after edge 5;
  - B_U is high exactly during the cycle after edge 5;
  - btn_level[4] falls 6 edges after the release is first sampled, with no pulse on release.
- Bounce rejection: btn_c_raw alternates 3 cycles high, 1 cycle low, for 20 cycles, then holds high →
  - no B_C pulse and btn_level[0]=0 during the bounce;
  - exactly one B_C pulse once the input has been steady high for 4 synchronised samples.
- Auto-repeat: btn_r_raw held high for 60 cycles, press pulse at cycle t →
  - B_R pulses at t, t+20, t+28, t+36, t+44, …, and none after release is debounced;
  - btn_c_raw held the same way → a single B_C pulse only.
- Simultaneous: btn_u_raw and btn_l_raw rise on the same edge → B_U and B_L pulse in the same cycle; other outputs stay 0.
- Reset mid-repeat: btn_d_raw held, FSM in REPEAT, reset asserted for 1 cycle with the pin still held →
  - B_D=0 and btn_level=0 after the reset edge;
  - a new B_D press pulse 6 cycles after reset deasserts;
  - the first repeat pulse 20 cycles after that.

Source files
------------

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and pulse-generate the five board push-buttons
module button_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 1_000_000,
    parameter int         REPEAT_DELAY    = 50_000_000,
    parameter int         REPEAT_PERIOD   = 10_000_000,
    parameter logic [4:0] REPEAT_MASK     = 5'b11110,
    parameter int         CNT_W           = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_u_raw,
    input  logic       btn_d_raw,
    input  logic       btn_l_raw,
    input  logic       btn_r_raw,
    input  logic       btn_c_raw,
    output logic       B_U,
    output logic       B_D,
    output logic       B_L,
    output logic       B_R,
    output logic       B_C,
    output logic [4:0] btn_level
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Bit order everywhere is {U,D,L,R,C}
    logic [4:0] w_raw;
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_level;
    logic [4:0] w_pulse;

    assign w_raw = {btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, btn_c_raw};

    // Two-flop synchroniser per raw pin, nothing between the stages
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_btn
        logic             r_stable;
        logic [CNT_W-1:0] r_db_cnt;
        logic             r_pulse;
        logic             w_flip;
        logic             w_rise;
        logic             w_rep_fire;

        // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample
        assign w_flip = (r_sync2[g] != r_stable) && (r_db_cnt == DB_LAST);
        assign w_rise = w_flip && r_sync2[g];

        // Debounce: count consecutive samples that differ from the stable level
        always_ff @(posedge clk) begin
            if (reset) begin
                r_stable <= 1'b0;
                r_db_cnt <= '0;
            end else if (r_sync2[g] == r_stable) begin
                r_db_cnt <= '0;
            end else if (w_flip) begin
                r_stable <= r_sync2[g];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CNT_ONE;
            end
        end

        if (REPEAT_MASK[g]) begin : g_rep
            logic [1:0]       r_state;
            logic [CNT_W-1:0] r_rcnt;

            // Repeat tick is decided from the current state so it can be
            // registered in the same pulse flop as the press edge
            assign w_rep_fire = r_stable &&
                                (((r_state == ST_DELAY)  && (r_rcnt == RD_LAST)) ||
                                 ((r_state == ST_REPEAT) && (r_rcnt == RP_LAST)));

            // Auto-repeat FSM: a fresh press always restarts the delay phase
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= ST_IDLE;
                    r_rcnt  <= '0;
                end else if (w_rise) begin
                    r_state <= ST_DELAY;
                    r_rcnt  <= '0;
                end else begin
                    case (r_state)
                        ST_DELAY, ST_REPEAT: begin
                            if (!r_stable) begin
                                r_state <= ST_IDLE;
                                r_rcnt  <= '0;
                            end else if (w_rep_fire) begin
                                r_state <= ST_REPEAT;
                                r_rcnt  <= '0;
                            end else begin
                                r_rcnt <= r_rcnt + CNT_ONE;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_rcnt  <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_norep
            assign w_rep_fire = 1'b0;
        end

        // Output pulse register: press edge or repeat tick, never on release
        always_ff @(posedge clk) begin
            if (reset) begin
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= w_rise | w_rep_fire;
            end
        end

        assign w_level[g] = r_stable;
        assign w_pulse[g] = r_pulse;
    end

    assign btn_level = w_level;
    assign B_U       = w_pulse[4];
    assign B_D       = w_pulse[3];
    assign B_L       = w_pulse[2];
    assign B_R       = w_pulse[1];
    assign B_C       = w_pulse[0];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;
    localparam int         D    = 4;
    localparam int         RD   = 20;
    localparam int         RP   = 8;
    localparam logic [4:0] MASK = 5'b11110;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_u_raw = 1'b0;
    logic       btn_d_raw = 1'b0;
    logic       btn_l_raw = 1'b0;
    logic       btn_r_raw = 1'b0;
    logic       btn_c_raw = 1'b0;
    logic       B_U, B_D, B_L, B_R, B_C;
    logic [4:0] btn_level;
    logic [4:0] pulses;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_MASK    (MASK),
        .CNT_W          (26)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_u_raw(btn_u_raw),
        .btn_d_raw(btn_d_raw),
        .btn_l_raw(btn_l_raw),
        .btn_r_raw(btn_r_raw),
        .btn_c_raw(btn_c_raw),
        .B_U      (B_U),
        .B_D      (B_D),
        .B_L      (B_L),
        .B_R      (B_R),
        .B_C      (B_C),
        .btn_level(btn_level)
    );

    assign pulses = {B_U, B_D, B_L, B_R, B_C};

    // Reference model: 2-sample delay, "last D samples all differ" flip rule,
    // pulses at press time t, t+RD, t+RD+k*RP while the level stayed high
    logic [4:0] m_d1 = '0, m_d2 = '0, m_level = '0, m_pulse = '0;
    logic [4:0] m_hist[$];
    longint     m_press[5];
    longint     cyc = 0;

    always @(posedge clk) begin
        logic [4:0] seen, prev, nxt;
        logic       all_diff, p;
        longint     el;
        cyc = cyc + 1;
        if (reset) begin
            m_d1 = '0; m_d2 = '0; m_level = '0; m_pulse = '0;
            m_hist.delete();
            for (int b = 0; b < 5; b++) m_press[b] = -1;
        end else begin
            seen = m_d2;
            m_d2 = m_d1;
            m_d1 = {btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, btn_c_raw};
            m_hist.push_back(seen);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            prev = m_level;
            nxt  = prev;
            for (int b = 0; b < 5; b++) begin
                if (m_hist.size() == D) begin
                    all_diff = 1'b1;
                    foreach (m_hist[i]) if (m_hist[i][b] == prev[b]) all_diff = 1'b0;
                    if (all_diff) nxt[b] = ~prev[b];
                end
            end
            for (int b = 0; b < 5; b++) begin
                p = 1'b0;
                if (nxt[b] && !prev[b]) begin
                    p = 1'b1;
                end else if (MASK[b] && prev[b] && m_press[b] >= 0) begin
                    el = cyc - m_press[b];
                    if (el >= RD && ((el - RD) % RP) == 0) p = 1'b1;
                end
                m_pulse[b] = p;
                if (nxt[b] && !prev[b]) m_press[b] = cyc;
                else if (!nxt[b]) m_press[b] = -1;
            end
            m_level = nxt;
        end
    end

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, btn_c_raw} = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (btn_level !== 5'b00000 || pulses !== 5'b00000) begin
                n_bad++;
                $display("FAIL reset_hold k=%0d: level=%b pulses=%b, required 00000/00000", k, btn_level, pulses);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (btn_level !== 5'b00000 || pulses !== 5'b00000) begin
                n_bad++;
                $display("FAIL reset_after k=%0d: level=%b pulses=%b, required 00000/00000", k, btn_level, pulses);
            end
        end
    endtask

    task automatic test_clean_press();
        logic exp_lvl, exp_p;
        for (int k = 0; k < 25; k++) begin
            btn_u_raw = (k < 12);
            @(negedge clk);
            exp_lvl = (k >= 5 && k < 17);
            exp_p   = (k == 5);
            n_cmp++;
            if (btn_level !== {exp_lvl, 4'b0000} || pulses !== {exp_p, 4'b0000}) begin
                n_bad++;
                $display("FAIL clean_press k=%0d: level=%b pulses=%b, required %b/%b",
                         k, btn_level, pulses, {exp_lvl, 4'b0000}, {exp_p, 4'b0000});
            end
        end
        btn_u_raw = 1'b0;
        settle(4);
    endtask

    task automatic test_bounce();
        int npulse = 0;
        for (int k = 0; k < 45; k++) begin
            btn_c_raw = (k < 20) ? ((k % 4) != 3) : 1'b1;
            @(negedge clk);
            if (B_C === 1'b1) npulse++;
            n_cmp++;
            if (btn_level[0] !== (k >= 25) || B_C !== (k == 25)) begin
                n_bad++;
                $display("FAIL bounce k=%0d: level_c=%b B_C=%b, required %b/%b",
                         k, btn_level[0], B_C, (k >= 25), (k == 25));
            end
        end
        n_cmp++;
        if (npulse != 1) begin
            n_bad++;
            $display("FAIL bounce_count: pulses=%0d, required 1", npulse);
        end
        btn_c_raw = 1'b0;
        settle(12);
    endtask

    task automatic test_auto_repeat();
        int  nr = 0;
        logic er;
        for (int k = 0; k < 85; k++) begin
            btn_r_raw = (k < 62);
            btn_c_raw = (k < 62);
            @(negedge clk);
            er = (k == 5) || (k >= 25 && k <= 65 && ((k - 25) % 8) == 0);
            if (B_R === 1'b1) nr++;
            n_cmp++;
            if (B_R !== er || B_C !== (k == 5) || {B_U, B_D, B_L} !== 3'b000) begin
                n_bad++;
                $display("FAIL auto_repeat k=%0d: pulses=%b, required %b",
                         k, pulses, {3'b000, er, (k == 5)});
            end
            n_cmp++;
            if (btn_level[1] !== (k >= 5 && k < 67)) begin
                n_bad++;
                $display("FAIL auto_repeat_level k=%0d: level_r=%b, required %b", k, btn_level[1], (k >= 5 && k < 67));
            end
        end
        n_cmp++;
        if (nr != 7) begin
            n_bad++;
            $display("FAIL auto_repeat_count: B_R pulses=%0d, required 7", nr);
        end
        btn_r_raw = 1'b0;
        btn_c_raw = 1'b0;
        settle(4);
    endtask

    task automatic test_simultaneous();
        logic [4:0] ep, el;
        for (int k = 0; k < 25; k++) begin
            btn_u_raw = (k < 10);
            btn_l_raw = (k < 10);
            @(negedge clk);
            ep = (k == 5) ? 5'b10100 : 5'b00000;
            el = (k >= 5 && k < 15) ? 5'b10100 : 5'b00000;
            n_cmp++;
            if (pulses !== ep || btn_level !== el) begin
                n_bad++;
                $display("FAIL simultaneous k=%0d: pulses=%b level=%b, required %b/%b", k, pulses, btn_level, ep, el);
            end
        end
        btn_u_raw = 1'b0;
        btn_l_raw = 1'b0;
        settle(4);
    endtask

    task automatic test_reset_mid_repeat();
        btn_d_raw = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_cmp++;
            if (B_D !== (k == 5 || k == 25)) begin
                n_bad++;
                $display("FAIL pre_reset k=%0d: B_D=%b, required %b", k, B_D, (k == 5 || k == 25));
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pulses !== 5'b00000 || btn_level !== 5'b00000) begin
            n_bad++;
            $display("FAIL mid_reset: pulses=%b level=%b, required 00000/00000", pulses, btn_level);
        end
        reset = 1'b0;
        for (int j = 0; j < 31; j++) begin
            @(negedge clk);
            n_cmp++;
            if (B_D !== (j == 5 || j == 25) || btn_level[3] !== (j >= 5)) begin
                n_bad++;
                $display("FAIL post_reset j=%0d: B_D=%b level_d=%b, required %b/%b",
                         j, B_D, btn_level[3], (j == 5 || j == 25), (j >= 5));
            end
        end
        btn_d_raw = 1'b0;
        settle(12);
    endtask

    task automatic test_random();
        int         run[5];
        logic [4:0] val = '0;
        for (int b = 0; b < 5; b++) run[b] = 0;
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < 5; b++) begin
                if (run[b] == 0) begin
                    val[b] = 1'($urandom_range(0, 1));
                    run[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 60));
                end
                run[b]--;
            end
            {btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, btn_c_raw} = val;
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            n_cmp++;
            if (btn_level !== m_level) begin
                n_bad++;
                $display("FAIL random_level k=%0d: level=%b, required %b", k, btn_level, m_level);
            end
            n_cmp++;
            if (pulses !== m_pulse) begin
                n_bad++;
                $display("FAIL random_pulse k=%0d: pulses=%b, required %b", k, pulses, m_pulse);
            end
        end
        reset = 1'b0;
        {btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, btn_c_raw} = '0;
        settle(12);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_reset_mid_repeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
